// File: rtl/mem_access_pkg.sv
// Shared types for the memory access sequencer: FSM state encoding,
// RV32I load/store size codes and a funct3 -> access size decode.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsupported codes (011, 110, 111) fall through to a full word access.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane steering between a 32-bit memory word and the core.
// Load side extracts and sign/zero extends; store side merges new data
// into the previously read word so the memory can always write 4 bytes.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;
  size_t       size;

  // Lane selection and extension for loads, lane merge for stores.
  always_comb begin
    size       = f3_size(funct3);
    sgn        = ~funct3[2];
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = lane[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = word;
    case (size)
      SZ_B: begin
        load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
        store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{sgn & half_sel[15]}}, half_sel};
        if (lane[1]) store_data[31:16] = wdata[15:0];
        else         store_data[15:0]  = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer between the multicycle control FSM and the
// unified byte-addressable memory. Handles fetch, load and store, with
// read-modify-write for sub-word stores.
// Build option: MEM_ACCESS_MISALIGN_CHECK_EN rejects misaligned halfword,
// word and fetch requests (done with err, no memory strobe).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req; latches the request when it arrives
// RD      | mem_read held; wait counter runs down, then data captured
// WR      | mem_write for one cycle with the merged/stored word
// DONE    | one-cycle done pulse (err valid), back to IDLE
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              is_fetch,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ir,
  output logic [31:0]       mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic        fetch_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        misalign;
  logic        is_sw;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign is_sw = ~is_fetch & we & (f3_size(funct3) == SZ_W);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic err_q;

  // Alignment rule: fetch/word need addr[1:0]==0, halfword needs addr[0]==0.
  always_comb begin
    misalign = 1'b0;
    if (is_fetch) begin
      misalign = (addr[1:0] != 2'b00);
    end else begin
      case (f3_size(funct3))
        SZ_H:    misalign = addr[0];
        SZ_W:    misalign = (addr[1:0] != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end

  assign err = err_q & (state_q == ST_DONE);
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  mem_lane_align u_align (
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .lane       (lane_q),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; sw skips the read, sub-word stores read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (misalign)   state_d = ST_DONE;
          else if (is_sw) state_d = ST_WR;
          else            state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (cnt_q == 4'd0) state_d = (fetch_q || !we_q) ? ST_DONE : ST_WR;
      end
      ST_WR:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_read  = (state_q == ST_RD);
  assign mem_write = (state_q == ST_WR);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // Request latch, wait counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q   <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      wdata_q   <= 32'h0;
      cnt_q     <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      ir        <= 32'h0;
      mdr       <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            fetch_q  <= is_fetch;
            we_q     <= we;
            f3_q     <= funct3;
            lane_q   <= addr[1:0];
            wdata_q  <= wdata;
            cnt_q    <= WAIT_INIT;
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            if (is_sw && !misalign) mem_wdata <= wdata;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            err_q    <= misalign;
`endif
          end
        end
        ST_RD: begin
          if (cnt_q != 4'd0)  cnt_q     <= cnt_q - 4'd1;
          else if (fetch_q)   ir        <= mem_rdata;
          else if (!we_q)     mdr       <= load_data;
          else                mem_wdata <= store_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: unit 0 runs with no wait states,
// unit 1 with three, each against its own small word memory.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req      [2];
  logic        is_fetch [2];
  logic        we       [2];
  logic [2:0]  f3       [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] maddr    [2];
  logic [31:0] mwdata   [2];
  logic        mread    [2];
  logic        mwrite   [2];
  logic [31:0] rdata    [2];
  logic [31:0] ir       [2];
  logic [31:0] mdr      [2];
  logic        busy     [2];
  logic        done     [2];
  logic        err      [2];

  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .req(req[0]), .is_fetch(is_fetch[0]), .we(we[0]),
    .funct3(f3[0]), .addr(addr[0]), .wdata(wdata[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwdata[0]), .mem_read(mread[0]), .mem_write(mwrite[0]),
    .mem_rdata(rdata[0]), .ir(ir[0]), .mdr(mdr[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  mem_access_unit #(.ADDR_W(32), .WAIT_STATES(3)) u1 (
    .clk(clk), .reset(reset), .req(req[1]), .is_fetch(is_fetch[1]), .we(we[1]),
    .funct3(f3[1]), .addr(addr[1]), .wdata(wdata[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwdata[1]), .mem_read(mread[1]), .mem_write(mwrite[1]),
    .mem_rdata(rdata[1]), .ir(ir[1]), .mdr(mdr[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata[0] = mem0[maddr[0][7:2]];
  assign rdata[1] = mem1[maddr[1][7:2]];

  always @(posedge clk) begin
    if (mwrite[0]) mem0[maddr[0][7:2]] <= mwdata[0];
    if (mwrite[1]) mem1[maddr[1][7:2]] <= mwdata[1];
  end

  // Drive one request and observe it until done (bounded at 40 cycles;
  // done_at stays 0 on timeout so the caller's check fails).
  task automatic run_access(input int u, input logic f, input logic w,
                            input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] wd,
                            output int rd_n, output int wr_n, output int done_at,
                            output logic err_at, output logic addr_ok);
    @(negedge clk);
    is_fetch[u] = f; we[u] = w; f3[u] = fn; addr[u] = a; wdata[u] = wd;
    req[u] = 1'b1;
    @(posedge clk);
    rd_n = 0; wr_n = 0; done_at = 0; err_at = 1'b0; addr_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req[u] = 1'b0;
      if (mread[u])  rd_n++;
      if (mwrite[u]) wr_n++;
      if (busy[u] && maddr[u] !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      if (done[u]) begin
        done_at = c;
        err_at  = err[u];
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; is_fetch[u] = 1'b0; we[u] = 1'b0; f3[u] = 3'b000;
      addr[u] = 32'h0; wdata[u] = 32'h0;
    end
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem0[35] = 32'h0000_0052;
    mem0[37] = 32'h1111_1111;
    mem1[0]  = 32'h0040_0293;
    mem1[35] = 32'h0000_00F0;
    #12;
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({mread[u], mwrite[u], busy[u], done[u], err[u]} !== 5'b0) begin
        bad++;
        $display("FAIL reset_strobes u%0d: got %b want 00000", u,
                 {mread[u], mwrite[u], busy[u], done[u], err[u]});
      end
      total++;
      if ({ir[u], mdr[u], mwdata[u], maddr[u]} !== 128'h0) begin
        bad++;
        $display("FAIL reset_regs u%0d: ir=%h mdr=%h wdata=%h addr=%h want 0", u,
                 ir[u], mdr[u], mwdata[u], maddr[u]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_byte();
    int rd_n, wr_n, dn; logic e, aok;
    run_access(0, 1'b0, 1'b0, 3'b000, 32'h8C, 32'h0, rd_n, wr_n, dn, e, aok);
    total++;
    if (rd_n !== 1 || wr_n !== 0 || dn !== 2) begin
      bad++;
      $display("FAIL lb_timing: rd=%0d wr=%0d done=%0d want 1 0 2", rd_n, wr_n, dn);
    end
    total++;
    if (mdr[0] !== 32'h0000_0052 || !aok || e !== 1'b0) begin
      bad++;
      $display("FAIL lb_data: mdr=%h addr_ok=%b err=%b want 00000052 1 0", mdr[0], aok, e);
    end
  endtask

  task automatic test_store_sub();
    int rd_n, wr_n, dn; logic e, aok;
    run_access(0, 1'b0, 1'b1, 3'b000, 32'h8D, 32'h0000_00AB, rd_n, wr_n, dn, e, aok);
    total++;
    if (rd_n !== 1 || wr_n !== 1 || dn !== 3 || !aok) begin
      bad++;
      $display("FAIL sb_timing: rd=%0d wr=%0d done=%0d aok=%b want 1 1 3 1", rd_n, wr_n, dn, aok);
    end
    total++;
    if (mwdata[0] !== 32'h0000_AB52 || mem0[35] !== 32'h0000_AB52) begin
      bad++;
      $display("FAIL sb_merge: mem_wdata=%h mem=%h want 0000ab52", mwdata[0], mem0[35]);
    end
    total++;
    if (mdr[0] !== 32'h0000_0052 || ir[0] !== 32'h0) begin
      bad++;
      $display("FAIL sb_no_side: mdr=%h ir=%h want 00000052 00000000", mdr[0], ir[0]);
    end
    run_access(0, 1'b0, 1'b1, 3'b001, 32'h8E, 32'hFFFF_1234, rd_n, wr_n, dn, e, aok);
    total++;
    if (mem0[35] !== 32'h1234_AB52 || dn !== 3 || wr_n !== 1) begin
      bad++;
      $display("FAIL sh_merge: mem=%h done=%0d wr=%0d want 1234ab52 3 1", mem0[35], dn, wr_n);
    end
  endtask

  task automatic test_load_ext();
    int rd_n, wr_n, dn; logic e, aok;
    logic [2:0]  fns  [5] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b011};
    logic [31:0] adrs [5] = '{32'h8C, 32'h8C, 32'h8D, 32'h8D, 32'h8C};
    logic [31:0] exps [5] = '{32'hFFFF_AB52, 32'h0000_AB52, 32'hFFFF_FFAB,
                              32'h0000_00AB, 32'h1234_AB52};
    mem0[35] = 32'h0000_AB52;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem0[35] = 32'h1234_AB52;
      run_access(0, 1'b0, 1'b0, fns[i], adrs[i], 32'h0, rd_n, wr_n, dn, e, aok);
      total++;
      if (mdr[0] !== exps[i] || dn !== 2 || wr_n !== 0 || ir[0] !== 32'h0) begin
        bad++;
        $display("FAIL load_ext f3=%b a=%h: mdr=%h done=%0d wr=%0d ir=%h want %h 2 0 0",
                 fns[i], adrs[i], mdr[0], dn, wr_n, ir[0], exps[i]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    int rd_n, wr_n, dn; logic e, aok;
    run_access(1, 1'b1, 1'b1, 3'b000, 32'h0, 32'hFFFF_FFFF, rd_n, wr_n, dn, e, aok);
    total++;
    if (rd_n !== 4 || wr_n !== 0 || dn !== 5 || !aok) begin
      bad++;
      $display("FAIL fetch_timing: rd=%0d wr=%0d done=%0d aok=%b want 4 0 5 1", rd_n, wr_n, dn, aok);
    end
    total++;
    if (ir[1] !== 32'h0040_0293 || mdr[1] !== 32'h0) begin
      bad++;
      $display("FAIL fetch_data: ir=%h mdr=%h want 00400293 00000000", ir[1], mdr[1]);
    end
  endtask

  task automatic test_store_word();
    int rd_n, wr_n, dn; logic e, aok;
    run_access(0, 1'b0, 1'b1, 3'b010, 32'h96, 32'hDEAD_BEEF, rd_n, wr_n, dn, e, aok);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    total++;
    if (dn !== 1 || e !== 1'b1 || rd_n !== 0 || wr_n !== 0) begin
      bad++;
      $display("FAIL sw_reject: done=%0d err=%b rd=%0d wr=%0d want 1 1 0 0", dn, e, rd_n, wr_n);
    end
    total++;
    if (mem0[37] !== 32'h1111_1111 || mdr[0] !== 32'h1234_AB52) begin
      bad++;
      $display("FAIL sw_reject_mem: mem=%h mdr=%h want 11111111 1234ab52", mem0[37], mdr[0]);
    end
`else
    total++;
    if (dn !== 2 || e !== 1'b0 || rd_n !== 0 || wr_n !== 1 || !aok) begin
      bad++;
      $display("FAIL sw_timing: done=%0d err=%b rd=%0d wr=%0d aok=%b want 2 0 0 1 1",
               dn, e, rd_n, wr_n, aok);
    end
    total++;
    if (mem0[37] !== 32'hDEAD_BEEF || maddr[0] !== 32'h94) begin
      bad++;
      $display("FAIL sw_data: mem=%h mem_addr=%h want deadbeef 00000094", mem0[37], maddr[0]);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    is_fetch[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; addr[1] = 32'h0;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    total++;
    if (mread[1] !== 1'b1) begin
      bad++;
      $display("FAIL midflight_rd: mem_read=%b want 1", mread[1]);
    end
    #3 reset = 1'b0;
    #1;
    total++;
    if (mread[1] !== 1'b0 || busy[1] !== 1'b0 || ir[1] !== 32'h0 || mdr[0] !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: mem_read=%b busy=%b ir=%h mdr0=%h want 0 0 0 0",
               mread[1], busy[1], ir[1], mdr[0]);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_req_ignored_busy();
    int n_done, done_at; logic addr_ok, idle_ok;
    int rd_n, wr_n, dn; logic e, aok;
    @(negedge clk);
    is_fetch[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; addr[1] = 32'h0;
    req[1] = 1'b1;
    @(posedge clk);
    n_done = 0; done_at = 0; addr_ok = 1'b1; idle_ok = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5 && maddr[1] !== 32'h0) addr_ok = 1'b0;
      if (done[1]) begin n_done++; done_at = c; end
      if (c >= 6 && busy[1]) idle_ok = 1'b0;
      is_fetch[1] = 1'b0; addr[1] = 32'h8C;
      req[1] = (c == 3 || c == 5);
    end
    req[1] = 1'b0;
    total++;
    if (n_done !== 1 || done_at !== 5 || !addr_ok || !idle_ok) begin
      bad++;
      $display("FAIL busy_ignore: n_done=%0d done_at=%0d addr_ok=%b idle_ok=%b want 1 5 1 1",
               n_done, done_at, addr_ok, idle_ok);
    end
    total++;
    if (ir[1] !== 32'h0040_0293 || mdr[1] !== 32'h0) begin
      bad++;
      $display("FAIL busy_ignore_regs: ir=%h mdr=%h want 00400293 00000000", ir[1], mdr[1]);
    end
    run_access(1, 1'b0, 1'b0, 3'b000, 32'h8C, 32'h0, rd_n, wr_n, dn, e, aok);
    total++;
    if (mdr[1] !== 32'hFFFF_FFF0 || dn !== 5 || rd_n !== 4 || ir[1] !== 32'h0040_0293) begin
      bad++;
      $display("FAIL idle_req_load: mdr=%h done=%0d rd=%0d ir=%h want fffffff0 5 4 00400293",
               mdr[1], dn, rd_n, ir[1]);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_sub();
    test_load_ext();
    test_fetch_wait();
    test_store_word();
    test_reset_midflight();
    test_req_ignored_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequencer between the multicycle control FSM and the byte-addressable unified memory.
- Accepts one fetch, load or store request at a time and drives the memory's read and write strobes.
- Word-aligns all memory addresses. Performs byte/halfword extraction with sign or zero extension on loads.
- Performs read-modify-write for sb/sh, because the memory always writes 4 bytes.
- Latches fetched words into the instruction register (IR) and load results into the memory data register (MDR).

Parameters:
- ADDR_W, 32, address width.
- WAIT_STATES, 0, extra cycles memory strobes are held before read data is captured (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe from control FSM; sampled in IDLE only.
- is_fetch  in  1  1 = instruction fetch (word read into IR); we and funct3 ignored.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data (rs2).
- mem_addr  out  ADDR_W  word-aligned address to memory ({addr[ADDR_W-1:2],2'b00}).
- mem_wdata  out  32  merged write word to memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  32  combinational read data from memory (valid while mem_read=1).
- ir  out  32  instruction register.
- mdr  out  32  memory data register (extended load result).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag, valid with done.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - ir, mdr, mem_wdata, mem_addr, the latched request and the wait counter clear to 0.
  - mem_read, mem_write, busy, done and err are 0 immediately, without waiting for a clock edge.
- Strobes: mem_read, mem_write, busy and done are decoded from state only (Moore outputs).
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On req=1, latch is_fetch, we, funct3, addr and wdata. Later input changes are ignored until the next IDLE.
  - Fetch, load, or sub-word store: go to RD.
  - sw: go to WR.
  - Misaligned request (see Optional Feature): go to DONE with err set.
- RD:
  - mem_read=1; the counter loads WAIT_STATES on entry.
  - Stay while counter≠0, decrementing each cycle.
  - On the cycle counter=0, capture mem_rdata.
  - Fetch: ir←word, mdr unchanged. Go to DONE.
  - Load: mdr←extracted lane, extended per funct3. Byte lane = addr[1:0]; halfword lane = addr[1]. Go to DONE.
  - sb/sh: merge wdata's low byte or halfword into the captured word at the lane, register the result into mem_wdata, go to WR.
- WR:
  - mem_write=1 for exactly one cycle, then go to DONE.
  - sw: mem_wdata=wdata.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - err is 0 unless the request was rejected.
  - A req asserted in DONE is ignored.
- Latency with WAIT_STATES=0, req accepted at edge 0:
  - Load/fetch: RD in cycle 1, done=1 in cycle 2.
  - sw: done=1 in cycle 2.
  - sb/sh: done=1 in cycle 3.
- Each extra wait state adds one cycle to any path through RD.
- Stores never modify ir or mdr.
- Loads never modify ir.
- Unsupported funct3 (011, 110, 111) is treated as word.
- mem_addr is held stable from request acceptance through DONE.

Optional Feature:
- Macro MEM_ACCESS_MISALIGN_CHECK_EN.
- Defined:
  - Misaligned requests are rejected: halfword with addr[0]=1, or word/fetch with addr[1:0]≠0.
  - Rejection path: IDLE→DONE with err=1; no strobe asserted; ir and mdr unchanged; done in cycle 1.
- Undefined:
  - err is tied to 0.
  - Halfword uses lane addr[1]; word ignores addr[1:0].
  - No rejection path.

Decomposition:
- Package mem_access_pkg:
  - State encoding for IDLE/RD/WR/DONE.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module mem_lane_align (combinational):
  - Load-side extract/extend from (word, addr[1:0], funct3).
  - Store-side merge from (word, wdata, addr[1:0], funct3).
- Top holds the FSM, wait counter and registers.

Test Plan:
- Word 0x8C=0x00000052, WAIT_STATES=0, lb addr=0x8C → mem_read high 1 cycle with mem_addr=0x8C; done cycle 2; mdr=0x00000052.
- sb wdata=0x000000AB addr=0x8D → RD then WR; mem_wdata=0x0000AB52; mem_write exactly 1 cycle. Then lh 0x8C → mdr=0xFFFFAB52; lhu 0x8C → mdr=0x0000AB52.
- Fetch addr=0x0 with word 0x00400293, WAIT_STATES=3 → mem_read held 4 cycles; ir=0x00400293; mdr unchanged; done at cycle 5.
- sw wdata=0xDEADBEEF addr=0x96 with check enabled → done+err cycle 1; mem_write never asserted; memory unchanged. Same test without macro → mem_addr=0x94, mem_write 1 cycle.
- reset driven low during RD → mem_read, busy 0 without a clock edge; ir/mdr=0. After release, req toggles while busy are ignored, and only a req seen in IDLE starts an access.
